fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that drives the decode stage's `insn`/`pc`/`enable_decode` inputs, i.e. the producer end of the fetch→decode interface.
- Keeps the fetch PC and issues word reads to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and hands one instruction per cycle to decode.
- Honours a decode-side stall and a branch/jump redirect that flushes everything in flight.

Parameters:
PC_RESET, 32'h80020000, fetch PC loaded on reset
DEPTH, 4, instruction buffer entries and max (outstanding + buffered) requests; power of 2, ≥2

Ports:
clock  in  1  single clock, all state updates on posedge
reset  in  1  synchronous, active-high
stall  in  1  decode cannot accept an instruction this cycle
redirect  in  1  branch/jump taken; flush and restart at redirect_pc
redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request this cycle
mem_addr  out  32  word address of request (= fetch PC)
mem_resp_valid  in  1  read data valid; responses return in request order
mem_resp_data  in  32  instruction word
insn  out  32  instruction to decode
pc  out  32  address of insn
enable_decode  out  1  insn/pc valid this cycle; one-cycle pulse per instruction

Behaviour:
- Reset (sync, any cycle, including mid-stream):
  - fetch_pc=PC_RESET; outstanding=0; drop=0; buffer emptied.
  - insn=0, pc=0, enable_decode=0, mem_req_valid=0 during the reset cycle.
  - A mem_resp_valid arriving while outstanding==0 is ignored.
- Request issue:
  - mem_req_valid=1 when !reset && !redirect && (outstanding + occupancy) < DEPTH, using current-cycle register values; no same-cycle credit return.
  - mem_addr=fetch_pc.
  - Handshake = mem_req_valid && mem_req_ready. On handshake: fetch_pc+=4 (32-bit wrap, no overflow flag); outstanding+=1; push fetch_pc into the in-order tag FIFO.
  - While ready=0, mem_addr and mem_req_valid are held stable.
- Response:
  - If drop>0: discard the data and tag; drop-=1; outstanding-=1.
  - Else: write {data, tag pc} to the buffer tail; outstanding-=1.
  - Credit rule guarantees the buffer never overflows. A response and a pop in the same cycle are both legal, including when the buffer is full.
- Output pop (registered):
  - If !redirect && !stall && occupancy>0: insn<=head data, pc<=head pc, enable_decode<=1, head popped.
  - Otherwise: enable_decode<=0; insn/pc hold last value.
- Latency:
  - Request handshake at cycle t, response at t+L → enable_decode=1 at t+L+2 (minimum).
  - Steady state with L=1, ready=1, DEPTH=4: one instruction per cycle.
- Redirect (priority over stall and request issue):
  - fetch_pc<=redirect_pc&~3.
  - Buffer emptied.
  - drop<=outstanding (minus 1 if a response is consumed that same cycle, which is also discarded).
  - enable_decode<=0 next cycle.
  - No request is issued in the redirect cycle.
  - The first instruction delivered afterwards has pc==redirect_pc.
- Simultaneous events:
  - Redirect+response: the response is dropped.
  - Reset+anything: reset wins.
  - Handshake+response in one cycle: outstanding unchanged.
- Counters outstanding/drop: $clog2(DEPTH+1) bits; never exceed DEPTH. The bench asserts no under/overflow.

Test Plan:
- Reset: hold reset 2 cycles → mem_addr=0x80020000, mem_req_valid=0 in reset cycles, enable_decode=0, insn=0, pc=0; first request after release at 0x80020000.
- Stream: L=1 memory returning insn=address, ready=1 → enable_decode=1 every cycle from request cycle+3, pc sequence 0x80020000, …04, …08, …, with insn==pc each time.
- Stall: stall high 5 cycles mid-stream → enable_decode=0, insn/pc frozen; at most 4 requests issued since the last pop; after release, pcs continue consecutively with none lost or repeated.
- Backpressure: mem_req_ready=0 for 3 cycles → mem_req_valid stays 1, mem_addr constant, fetch_pc not incremented.
- Redirect with 2 in flight: redirect_pc=0x80020103 at a cycle with outstanding=2 → both responses dropped; the next enable_decode shows pc=0x80020100; no stale insn delivered.
- Redirect+stall same cycle, and reset asserted with 3 in flight → redirect honoured (next pc=redirect_pc); after reset, late responses ignored and the first delivered pc=0x80020000.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// fetch->decode hand-off signals and the decode-side stall/redirect controls.
interface fetch_if;
  // Request channel: a transfer happens on a cycle where mem_req_valid and
  // mem_req_ready are both high. Once raised, valid and mem_addr stay stable
  // until that transfer, unless a redirect or reset intervenes.
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        enable_decode;

  modport master (
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  stall, redirect, redirect_pc,
    output mem_req_valid, mem_addr, insn, pc, enable_decode
  );

  modport slave (
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output stall, redirect, redirect_pc,
    input  mem_req_valid, mem_addr, insn, pc, enable_decode
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word reads, buffers responses and
// hands one instruction per cycle to decode; redirect flushes everything in flight.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h80020000,
  parameter int          DEPTH    = 4
) (
  input  logic     clock,
  input  logic     reset,
  fetch_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [31:0]   tag_mem [DEPTH];
  logic [AW:0]   tag_wr, tag_rd;

  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [AW:0]   buf_wr, buf_rd;
  logic [AW:0]   occupancy;

  logic [CW:0]   credit_used;
  logic          req_valid, handshake, resp_fire, resp_keep, pop;

  always_comb begin
    occupancy   = buf_wr - buf_rd;
    credit_used = (CW+1)'(outstanding) + (CW+1)'(occupancy);
    // Credit counts both in-flight and buffered words so the buffer can never overflow.
    req_valid   = !reset && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
    handshake   = req_valid && bus.mem_req_ready;
    resp_fire   = bus.mem_resp_valid && (outstanding != '0);
    resp_keep   = resp_fire && (drop == '0) && !bus.redirect;
    pop         = !bus.redirect && !bus.stall && (occupancy != '0);
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_addr      = fetch_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc          <= PC_RESET;
      outstanding       <= '0;
      drop              <= '0;
      tag_wr            <= '0;
      tag_rd            <= '0;
      buf_wr            <= '0;
      buf_rd            <= '0;
      bus.insn          <= '0;
      bus.pc            <= '0;
      bus.enable_decode <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(handshake) - CW'(resp_fire);
      if (handshake) tag_wr <= tag_wr + 1'b1;
      if (resp_fire) tag_rd <= tag_rd + 1'b1;

      if (bus.redirect) begin
        fetch_pc          <= bus.redirect_pc & ~32'h3;
        // Every request still in flight now belongs to the abandoned path.
        drop              <= outstanding - CW'(resp_fire);
        buf_wr            <= '0;
        buf_rd            <= '0;
        bus.enable_decode <= 1'b0;
      end else begin
        if (handshake) fetch_pc <= fetch_pc + 32'd4;
        if (resp_fire && (drop != '0)) drop <= drop - 1'b1;
        if (resp_keep) buf_wr <= buf_wr + 1'b1;
        if (pop) begin
          bus.insn          <= buf_data[buf_rd[AW-1:0]];
          bus.pc            <= buf_pc[buf_rd[AW-1:0]];
          bus.enable_decode <= 1'b1;
          buf_rd            <= buf_rd + 1'b1;
        end else begin
          bus.enable_decode <= 1'b0;
        end
      end
    end
  end

  // Storage arrays carry no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (handshake) tag_mem[tag_wr[AW-1:0]] <= fetch_pc;
    if (resp_keep && !reset) begin
      buf_data[buf_wr[AW-1:0]] <= bus.mem_resp_data;
      buf_pc[buf_wr[AW-1:0]]   <= tag_mem[tag_rd[AW-1:0]];
    end
  end
endmodule
